// File: rtl/gbt_rx_frame_decoder.sv
`timescale 1ns/100ps
// gbt_rx_frame_decoder
//   Checks framing on a received 84-bit GBT frame stream. It verifies a
//   16-bit additive checksum and a 4-bit rolling sequence number. It runs a
//   lock state machine (UNLOCKED -> CHECKING -> LOCKED) and forwards the
//   payload of every good frame that is evaluated while locked.
//
// Ports
//   clk_ik          : 40 MHz frame clock
//   rstn_ir         : asynchronous active-low reset
//   frame_ib84      : {sc[1:0], ic[1:0], data[79:0]}
//   frame_valid_i   : frame is meaningful this cycle
//   clr_counters_i  : synchronous clear of err/good counters
//   payload_ob56    : data[71:16] of last accepted frame
//   type_ob4        : data[79:76] of last accepted frame
//   ic_ob2, sc_ob2  : ic / sc bits of last accepted frame
//   payload_valid_o : one-cycle accept strobe
//   locked_o        : decoder is in LOCKED
//   chk_err_o       : one-cycle checksum error strobe
//   seq_err_o       : one-cycle sequence error strobe
//   err_cnt_ob16    : saturating bad-frame count
//   good_cnt_ob32   : wrapping accepted-frame count
module gbt_rx_frame_decoder #(
  parameter int unsigned LOCK_CNT   = 8,
  parameter int unsigned UNLOCK_CNT = 4
) (
  input  logic        clk_ik,
  input  logic        rstn_ir,
  input  logic [83:0] frame_ib84,
  input  logic        frame_valid_i,
  input  logic        clr_counters_i,
  output logic [55:0] payload_ob56,
  output logic [3:0]  type_ob4,
  output logic [1:0]  ic_ob2,
  output logic [1:0]  sc_ob2,
  output logic        payload_valid_o,
  output logic        locked_o,
  output logic        chk_err_o,
  output logic        seq_err_o,
  output logic [15:0] err_cnt_ob16,
  output logic [31:0] good_cnt_ob32
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_CHECKING = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_CNT_8   = 8'(LOCK_CNT);
  localparam logic [7:0] UNLOCK_CNT_8 = 8'(UNLOCK_CNT);

  // Sum of the four 16-bit words W3..W0, modulo 2^16
  function automatic logic [15:0] f_chk_sum(input logic [79:0] d);
    return d[79:64] + d[63:48] + d[47:32] + d[31:16];
  endfunction

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_exp_seq, w_exp_seq_nxt;
  logic [7:0]  r_good_run, w_good_run_nxt;
  logic [7:0]  r_bad_run, w_bad_run_nxt;
  logic        w_accept, w_chk_err, w_seq_err, w_err_inc;
  logic        w_chk_ok, w_seq_ok, w_good;
  logic [3:0]  w_seq;
  logic [7:0]  w_good_inc, w_bad_inc;

  logic [55:0] r_payload;
  logic [3:0]  r_type;
  logic [1:0]  r_ic, r_sc;
  logic        r_payload_valid, r_locked, r_chk_err, r_seq_err;
  logic [15:0] r_err_cnt;
  logic [31:0] r_good_cnt;

  assign w_seq      = frame_ib84[75:72];
  assign w_chk_ok   = (f_chk_sum(frame_ib84[79:0]) == frame_ib84[15:0]);
  assign w_seq_ok   = (w_seq == r_exp_seq);
  assign w_good     = w_chk_ok && w_seq_ok;
  assign w_good_inc = r_good_run + 8'd1;
  assign w_bad_inc  = r_bad_run + 8'd1;

  // Next-state, run-counter and strobe decode for the evaluated frame
  always_comb begin
    w_state_nxt    = r_state;
    w_exp_seq_nxt  = r_exp_seq;
    w_good_run_nxt = r_good_run;
    w_bad_run_nxt  = r_bad_run;
    w_accept       = 1'b0;
    w_chk_err      = 1'b0;
    w_seq_err      = 1'b0;
    w_err_inc      = 1'b0;
    if (frame_valid_i) begin
      case (r_state)
        ST_UNLOCKED: begin
          // Sequence is not checked here; a good checksum seeds exp_seq
          if (w_chk_ok) begin
            w_exp_seq_nxt  = w_seq + 4'd1;
            w_good_run_nxt = 8'd1;
            w_state_nxt    = ST_CHECKING;
          end else begin
            w_chk_err = 1'b1;
          end
        end
        ST_CHECKING: begin
          if (w_good) begin
            w_exp_seq_nxt = r_exp_seq + 4'd1;
            if (w_good_inc == LOCK_CNT_8) begin
              // The frame completing the lock run is already accepted
              w_state_nxt    = ST_LOCKED;
              w_good_run_nxt = 8'd0;
              w_accept       = 1'b1;
            end else begin
              w_good_run_nxt = w_good_inc;
            end
          end else begin
            w_chk_err      = !w_chk_ok;
            w_seq_err      = w_chk_ok;
            w_err_inc      = 1'b1;
            w_good_run_nxt = 8'd0;
            w_state_nxt    = ST_UNLOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_good) begin
            w_bad_run_nxt = 8'd0;
            w_exp_seq_nxt = r_exp_seq + 4'd1;
            w_accept      = 1'b1;
          end else begin
            w_chk_err = !w_chk_ok;
            w_seq_err = w_chk_ok;
            w_err_inc = 1'b1;
            // A trustworthy frame resynchronises the sequence; a corrupt one
            // only advances it
            w_exp_seq_nxt = w_chk_ok ? (w_seq + 4'd1) : (r_exp_seq + 4'd1);
            if (w_bad_inc == UNLOCK_CNT_8) begin
              w_bad_run_nxt = 8'd0;
              w_state_nxt   = ST_UNLOCKED;
            end else begin
              w_bad_run_nxt = w_bad_inc;
            end
          end
        end
        default: begin
          w_state_nxt    = ST_UNLOCKED;
          w_exp_seq_nxt  = 4'd0;
          w_good_run_nxt = 8'd0;
          w_bad_run_nxt  = 8'd0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Lock state, expected sequence and run counters
  always_ff @(posedge clk_ik or negedge rstn_ir) begin
    if (!rstn_ir) begin
      r_state    <= ST_UNLOCKED;
      r_exp_seq  <= 4'd0;
      r_good_run <= 8'd0;
      r_bad_run  <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_exp_seq  <= w_exp_seq_nxt;
      r_good_run <= w_good_run_nxt;
      r_bad_run  <= w_bad_run_nxt;
    end
  end

  // Registered outputs: accepted fields, strobes, lock flag and counters
  always_ff @(posedge clk_ik or negedge rstn_ir) begin
    if (!rstn_ir) begin
      r_payload       <= 56'd0;
      r_type          <= 4'd0;
      r_ic            <= 2'd0;
      r_sc            <= 2'd0;
      r_payload_valid <= 1'b0;
      r_locked        <= 1'b0;
      r_chk_err       <= 1'b0;
      r_seq_err       <= 1'b0;
      r_err_cnt       <= 16'd0;
      r_good_cnt      <= 32'd0;
    end else begin
      r_payload_valid <= w_accept;
      r_chk_err       <= w_chk_err;
      r_seq_err       <= w_seq_err;
      r_locked        <= (w_state_nxt == ST_LOCKED);
      if (w_accept) begin
        r_payload <= frame_ib84[71:16];
        r_type    <= frame_ib84[79:76];
        r_ic      <= frame_ib84[81:80];
        r_sc      <= frame_ib84[83:82];
      end
      // Clear wins over any increment in the same cycle
      if (clr_counters_i) begin
        r_err_cnt  <= 16'd0;
        r_good_cnt <= 32'd0;
      end else begin
        if (w_err_inc && (r_err_cnt != 16'hFFFF)) begin
          r_err_cnt <= r_err_cnt + 16'd1;
        end
        if (w_accept) begin
          r_good_cnt <= r_good_cnt + 32'd1;
        end
      end
    end
  end

  assign payload_ob56    = r_payload;
  assign type_ob4        = r_type;
  assign ic_ob2          = r_ic;
  assign sc_ob2          = r_sc;
  assign payload_valid_o = r_payload_valid;
  assign locked_o        = r_locked;
  assign chk_err_o       = r_chk_err;
  assign seq_err_o       = r_seq_err;
  assign err_cnt_ob16    = r_err_cnt;
  assign good_cnt_ob32   = r_good_cnt;

endmodule

// File: tb/tb_gbt_rx_frame_decoder.sv
`timescale 1ns/100ps
// Testbench for gbt_rx_frame_decoder: directed scenarios plus random traffic,
// checked every cycle against a frame-level behavioural model.
module tb_gbt_rx_frame_decoder;
  localparam int LOCK   = 8;
  localparam int UNLOCK = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [83:0] frame_r = 84'd0;
  logic        valid_r = 1'b0;
  logic        clr_r = 1'b0;
  logic [55:0] payload_ob56;
  logic [3:0]  type_ob4;
  logic [1:0]  ic_ob2, sc_ob2;
  logic        payload_valid_o, locked_o, chk_err_o, seq_err_o;
  logic [15:0] err_cnt_ob16;
  logic [31:0] good_cnt_ob32;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  gbt_rx_frame_decoder #(.LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK)) dut (
    .clk_ik(clk), .rstn_ir(rstn), .frame_ib84(frame_r), .frame_valid_i(valid_r),
    .clr_counters_i(clr_r), .payload_ob56(payload_ob56), .type_ob4(type_ob4),
    .ic_ob2(ic_ob2), .sc_ob2(sc_ob2), .payload_valid_o(payload_valid_o),
    .locked_o(locked_o), .chk_err_o(chk_err_o), .seq_err_o(seq_err_o),
    .err_cnt_ob16(err_cnt_ob16), .good_cnt_ob32(good_cnt_ob32)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_mode = 0;          // 0 unlocked, 1 checking, 2 locked
  logic [3:0]  m_exp = 4'd0;
  int          m_gr = 0, m_br = 0;
  logic [55:0] m_payload = 56'd0;
  logic [3:0]  m_type = 4'd0;
  logic [1:0]  m_ic = 2'd0, m_sc = 2'd0;
  logic        m_pv = 1'b0, m_ce = 1'b0, m_se = 1'b0;
  logic [15:0] m_err = 16'd0;
  logic [31:0] m_good = 32'd0;

  task automatic model_reset();
    m_mode = 0; m_exp = 4'd0; m_gr = 0; m_br = 0;
    m_payload = 56'd0; m_type = 4'd0; m_ic = 2'd0; m_sc = 2'd0;
    m_pv = 1'b0; m_ce = 1'b0; m_se = 1'b0; m_err = 16'd0; m_good = 32'd0;
  endtask

  task automatic model_step();
    logic [79:0] d;
    logic [15:0] sum;
    logic [3:0]  seq;
    bit ck, sq, good, acc, errinc;
    d = frame_r[79:0];
    seq = d[75:72];
    sum = d[79:64] + d[63:48] + d[47:32] + d[31:16];
    ck = (sum == d[15:0]);
    sq = (seq == m_exp);
    good = ck && sq;
    acc = 1'b0; errinc = 1'b0;
    m_pv = 1'b0; m_ce = 1'b0; m_se = 1'b0;
    if (valid_r) begin
      if (m_mode == 0) begin
        if (ck) begin m_exp = 4'(seq + 4'd1); m_gr = 1; m_mode = 1; end
        else m_ce = 1'b1;
      end else begin
        if (!good) begin m_ce = !ck; m_se = ck && !sq; errinc = 1'b1; end
        if (m_mode == 1) begin
          if (good) begin
            m_gr++; m_exp = 4'(m_exp + 4'd1);
            if (m_gr == LOCK) begin m_mode = 2; m_gr = 0; acc = 1'b1; end
          end else begin
            m_mode = 0; m_gr = 0;
          end
        end else begin
          if (good) begin
            m_br = 0; m_exp = 4'(m_exp + 4'd1); acc = 1'b1;
          end else begin
            m_br++;
            m_exp = ck ? 4'(seq + 4'd1) : 4'(m_exp + 4'd1);
            if (m_br == UNLOCK) begin m_mode = 0; m_br = 0; end
          end
        end
      end
    end
    if (acc) begin
      m_payload = d[71:16]; m_type = d[79:76];
      m_ic = frame_r[81:80]; m_sc = frame_r[83:82];
    end
    m_pv = acc;
    if (clr_r) begin
      m_err = 16'd0; m_good = 32'd0;
    end else begin
      if (errinc && m_err != 16'hFFFF) m_err = m_err + 16'd1;
      if (acc) m_good = m_good + 32'd1;
    end
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) model_reset();
    else model_step();
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("payload", 64'(payload_ob56), 64'(m_payload));
      check("type", 64'(type_ob4), 64'(m_type));
      check("ic", 64'(ic_ob2), 64'(m_ic));
      check("sc", 64'(sc_ob2), 64'(m_sc));
      check("payload_valid", 64'(payload_valid_o), 64'(m_pv));
      check("locked", 64'(locked_o), 64'(m_mode == 2));
      check("chk_err", 64'(chk_err_o), 64'(m_ce));
      check("seq_err", 64'(seq_err_o), 64'(m_se));
      check("err_cnt", 64'(err_cnt_ob16), 64'(m_err));
      check("good_cnt", 64'(good_cnt_ob32), 64'(m_good));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [83:0] mk_frame(input logic [3:0] seq, input logic [15:0] corrupt);
    logic [79:0] d;
    logic [15:0] s;
    d[79:16] = {$urandom(), $urandom()};
    d[75:72] = seq;
    s = d[79:64] + d[63:48] + d[47:32] + d[31:16];
    d[15:0] = s + corrupt;
    return {4'($urandom()), d};
  endfunction

  task automatic send(input logic [83:0] f, input logic v, input logic c);
    @(negedge clk);
    frame_r = f; valid_r = v; clr_r = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) send(frame_r, 1'b0, 1'b0);
  endtask

  task automatic lock_up(input logic [3:0] start);
    for (int k = 0; k < LOCK; k++) begin
      send(mk_frame(4'(start + 4'(k)), 16'd0), 1'b1, 1'b0);
      check("lock_progress", 64'(locked_o), (k == LOCK - 1) ? 64'd1 : 64'd0);
    end
  endtask

  logic [3:0] s;
  logic [3:0] nseq;

  initial begin
    @(posedge clk); #1;
    cmp_en = 1'b1;
    check("reset_locked", 64'(locked_o), 64'd0);
    check("reset_good_cnt", 64'(good_cnt_ob32), 64'd0);
    @(negedge clk); rstn = 1'b1;

    // Lock with seq 3..10
    lock_up(4'd3);
    check("lock_pv", 64'(payload_valid_o), 64'd1);
    check("lock_good_cnt", 64'(good_cnt_ob32), 64'd1);

    // Checksum error while locked, then next frame accepted
    send(mk_frame(4'd11, 16'd1), 1'b1, 1'b0);
    check("chkerr_strobe", 64'(chk_err_o), 64'd1);
    check("chkerr_pv", 64'(payload_valid_o), 64'd0);
    check("chkerr_locked", 64'(locked_o), 64'd1);
    check("chkerr_cnt", 64'(err_cnt_ob16), 64'd1);
    send(mk_frame(4'd12, 16'd0), 1'b1, 1'b0);
    check("after_chkerr_pv", 64'(payload_valid_o), 64'd1);

    // 3 bad then good keeps lock; then 4 bad drops it
    s = 4'd13;
    for (int k = 0; k < 3; k++) begin send(mk_frame(s, 16'h0100), 1'b1, 1'b0); s = s + 4'd1; end
    check("3bad_locked", 64'(locked_o), 64'd1);
    send(mk_frame(s, 16'd0), 1'b1, 1'b0); s = s + 4'd1;
    check("3bad_good_pv", 64'(payload_valid_o), 64'd1);
    for (int k = 0; k < 4; k++) begin
      send(mk_frame(s, 16'h0100), 1'b1, 1'b0); s = s + 4'd1;
      check("unlock_run", 64'(locked_o), (k == 3) ? 64'd0 : 64'd1);
    end
    check("err_cnt_8", 64'(err_cnt_ob16), 64'd8);

    // Relock, then sequence wrap with gaps
    lock_up(4'd6);
    s = 4'd14;
    for (int k = 0; k < 4; k++) begin
      send(mk_frame(s, 16'd0), 1'b1, 1'b0); s = s + 4'd1;
      check("wrap_pv", 64'(payload_valid_o), 64'd1);
      check("wrap_seq_err", 64'(seq_err_o), 64'd0);
      idle(2);
      check("gap_pv", 64'(payload_valid_o), 64'd0);
    end
    check("wrap_good_cnt", 64'(good_cnt_ob32), 64'd8);

    // Saturation and clear priority
    @(negedge clk); #1;
    force dut.r_err_cnt = 16'hFFFE;
    m_err = 16'hFFFE;
    #1 release dut.r_err_cnt;
    send(mk_frame(s, 16'h0001), 1'b1, 1'b0); s = s + 4'd1;
    check("sat_ffff", 64'(err_cnt_ob16), 64'hFFFF);
    send(mk_frame(s, 16'h0001), 1'b1, 1'b0); s = s + 4'd1;
    check("sat_hold", 64'(err_cnt_ob16), 64'hFFFF);
    send(mk_frame(s, 16'd0), 1'b1, 1'b1); s = s + 4'd1;
    check("clr_pv", 64'(payload_valid_o), 64'd1);
    check("clr_good", 64'(good_cnt_ob32), 64'd0);
    check("clr_err", 64'(err_cnt_ob16), 64'd0);
    check("clr_locked", 64'(locked_o), 64'd1);

    // Reset pulse between edges while locked
    send(mk_frame(s, 16'd0), 1'b1, 1'b0); s = s + 4'd1;
    idle(1);
    @(posedge clk); #2;
    rstn = 1'b0;
    #0.5;
    check("rst_locked", 64'(locked_o), 64'd0);
    check("rst_good_cnt", 64'(good_cnt_ob32), 64'd0);
    check("rst_payload", 64'(payload_ob56), 64'd0);
    #0.5 rstn = 1'b1;
    lock_up(s);

    // Random traffic
    nseq = s + 4'(LOCK);
    for (int k = 0; k < 3000; k++) begin
      logic v, c;
      logic [3:0] sq;
      logic [15:0] cor;
      v = ($urandom_range(3) != 0);
      c = ($urandom_range(63) == 0);
      sq = ($urandom_range(7) == 0) ? 4'($urandom()) : nseq;
      cor = ($urandom_range(9) == 0) ? 16'($urandom_range(1, 65535)) : 16'd0;
      send(mk_frame(sq, cor), v, c);
      if (v) nseq = sq + 4'd1;
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
